// File: rtl/muldiv_pkg.sv
// +--------------------------------------------------------------------+
// | muldiv_pkg: shared constants, FSM state and request/response types |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

package muldiv_pkg;

  localparam int MD_XLEN   = 32;
  localparam int MD_REG_AW = 5;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } md_state_t;

  typedef struct packed {
    logic [2:0]           op;
    logic [MD_XLEN-1:0]   a;
    logic [MD_XLEN-1:0]   b;
    logic [MD_REG_AW-1:0] rd;
  } muldiv_req_t;

  typedef struct packed {
    logic [MD_XLEN-1:0]   result;
    logic [MD_REG_AW-1:0] rd;
    logic                 N;
    logic                 Z;
  } muldiv_rsp_t;

  function automatic logic op_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic op_is_rem(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_step.sv
// +--------------------------------------------------------------------+
// | muldiv_step: one shift-add (multiply) or trial-subtract (divide)   |
// | iteration over a {hi, lo} accumulator pair.                         |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] opnd,
  output logic [XLEN-1:0] hi_next,
  output logic [XLEN-1:0] lo_next
);

  logic [XLEN:0] w_sum;
  logic [XLEN:0] w_shifted;
  logic [XLEN:0] w_diff;

  always_comb begin
    w_sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
    w_shifted = {hi, lo[XLEN-1]};
    w_diff    = w_shifted - {1'b0, opnd};
    if (is_div) begin
      // Partial remainder is always below the divisor, so bit XLEN of the
      // difference is exactly the borrow.
      hi_next = w_diff[XLEN] ? w_shifted[XLEN-1:0] : w_diff[XLEN-1:0];
      lo_next = {lo[XLEN-2:0], ~w_diff[XLEN]};
    end else begin
      hi_next = w_sum[XLEN:1];
      lo_next = {w_sum[0], lo[XLEN-1:1]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// +--------------------------------------------------------------------+
// | muldiv_unit: iterative RV32M/RV64M multiply/divide unit with       |
// | valid/ready request and response handshakes.                        |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [XLEN-1:0]   in_a,
  input  logic [XLEN-1:0]   in_b,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              kill,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_result,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_N,
  output logic              out_Z,
  output logic              stall
);

  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CW-1:0]   LAST_IT = CW'(XLEN - 1);

  md_state_t         r_state;
  logic [CW-1:0]     r_cnt;
  logic [2:0]        r_op;
  logic              r_sa;
  logic              r_sb;
  logic              r_special;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic [XLEN-1:0]   r_opnd;
  logic [REG_AW-1:0] r_rd;

  logic              w_is_div;
  logic              w_a_signed;
  logic              w_b_signed;
  logic              w_sa;
  logic              w_sb;
  logic              w_div_zero;
  logic              w_div_ovf;
  logic [XLEN-1:0]   w_abs_a;
  logic [XLEN-1:0]   w_abs_b;
  logic [XLEN-1:0]   w_spec_result;

  logic [XLEN-1:0]   w_hi_next;
  logic [XLEN-1:0]   w_lo_next;
  logic              w_run_div;

  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quot;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_fix_result;

  assign in_ready  = (r_state == ST_IDLE);
  assign w_run_div = op_is_div(r_op);

  // Request decode: operand signedness, magnitudes and the divide corner cases.
  always_comb begin
    w_is_div   = op_is_div(in_op);
    w_a_signed = (in_op == F3_MUL) || (in_op == F3_MULH) || (in_op == F3_MULHSU) ||
                 (in_op == F3_DIV) || (in_op == F3_REM);
    w_b_signed = (in_op == F3_MUL) || (in_op == F3_MULH) ||
                 (in_op == F3_DIV) || (in_op == F3_REM);
    w_sa       = w_a_signed & in_a[XLEN-1];
    w_sb       = w_b_signed & in_b[XLEN-1];
    w_abs_a    = w_sa ? -in_a : in_a;
    w_abs_b    = w_sb ? -in_b : in_b;
    w_div_zero = w_is_div && (in_b == '0);
    w_div_ovf  = w_is_div && w_b_signed && (in_a == MIN_NEG) && (in_b == '1);
    w_spec_result = '1;
    if (w_div_zero) begin
      w_spec_result = op_is_rem(in_op) ? in_a : '1;
    end else if (w_div_ovf) begin
      w_spec_result = op_is_rem(in_op) ? '0 : in_a;
    end
  end

  muldiv_step #(
    .XLEN (XLEN)
  ) u_step (
    .is_div  (w_run_div),
    .hi      (r_hi),
    .lo      (r_lo),
    .opnd    (r_opnd),
    .hi_next (w_hi_next),
    .lo_next (w_lo_next)
  );

  // Sign fix-up; negating the most negative value wraps to itself, which is
  // exactly the required result for those operands.
  always_comb begin
    w_prod = {r_hi, r_lo};
    if (r_sa ^ r_sb) begin
      w_prod = -w_prod;
    end
    w_quot = (r_sa ^ r_sb) ? -r_lo : r_lo;
    w_rem  = r_sa ? -r_hi : r_hi;
    case (r_op)
      F3_MUL:                       w_fix_result = w_prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: w_fix_result = w_prod[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              w_fix_result = w_quot;
      default:                      w_fix_result = w_rem;
    endcase
    if (r_special) begin
      w_fix_result = r_lo;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_op       <= '0;
      r_sa       <= 1'b0;
      r_sb       <= 1'b0;
      r_special  <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_opnd     <= '0;
      r_rd       <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_rd     <= '0;
      out_N      <= 1'b0;
      out_Z      <= 1'b0;
      stall      <= 1'b0;
    end else if (kill) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      out_valid <= 1'b0;
      stall     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_op      <= in_op;
            r_sa      <= w_sa;
            r_sb      <= w_sb;
            r_rd      <= in_rd;
            r_cnt     <= '0;
            r_hi      <= '0;
            r_special <= w_div_zero | w_div_ovf;
            stall     <= 1'b1;
            // Corner cases skip the iterations; FIX forwards the preset result.
            if (w_div_zero | w_div_ovf) begin
              r_lo    <= w_spec_result;
              r_opnd  <= '0;
              r_state <= ST_FIX;
            end else begin
              r_lo    <= w_is_div ? w_abs_a : w_abs_b;
              r_opnd  <= w_is_div ? w_abs_b : w_abs_a;
              r_state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          r_hi  <= w_hi_next;
          r_lo  <= w_lo_next;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST_IT) begin
            r_state <= ST_FIX;
          end
        end
        ST_FIX: begin
          out_result <= w_fix_result;
          out_rd     <= r_rd;
          out_N      <= w_fix_result[XLEN-1];
          out_Z      <= (w_fix_result == '0);
          out_valid  <= 1'b1;
          r_state    <= ST_DONE;
        end
        default: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            stall     <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// +--------------------------------------------------------------------+
// | tb_muldiv_unit: directed self-checking bench for muldiv_unit and   |
// | its muldiv_step iteration datapath.                                 |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [2:0]        in_op = '0;
  logic [XLEN-1:0]   in_a = '0;
  logic [XLEN-1:0]   in_b = '0;
  logic [REG_AW-1:0] in_rd = '0;
  logic              kill = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [XLEN-1:0]   out_result;
  logic [REG_AW-1:0] out_rd;
  logic              out_N;
  logic              out_Z;
  logic              stall;

  logic              s_div = 1'b0;
  logic [XLEN-1:0]   s_hi = '0;
  logic [XLEN-1:0]   s_lo = '0;
  logic [XLEN-1:0]   s_opnd = '0;
  logic [XLEN-1:0]   s_hi_next;
  logic [XLEN-1:0]   s_lo_next;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  muldiv_unit #(
    .XLEN   (XLEN),
    .REG_AW (REG_AW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_rd      (in_rd),
    .kill       (kill),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_rd     (out_rd),
    .out_N      (out_N),
    .out_Z      (out_Z),
    .stall      (stall)
  );

  muldiv_step #(
    .XLEN (XLEN)
  ) step_dut (
    .is_div  (s_div),
    .hi      (s_hi),
    .lo      (s_lo),
    .opnd    (s_opnd),
    .hi_next (s_hi_next),
    .lo_next (s_lo_next)
  );

  // Presents one request in IDLE and returns the number of rising edges from
  // the accept edge (counted as 1) until out_valid is first seen.
  task automatic run_op(input logic [2:0] op, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [REG_AW-1:0] rd,
                        output int lat);
    @(negedge clk);
    in_op = op; in_a = a; in_b = b; in_rd = rd; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    lat = 1;
    #1;
    in_valid = 1'b0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      lat++;
      #1;
    end
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got ready=%b valid=%b stall=%b want 1 0 0", in_ready, out_valid, stall);
    end
    vectors++;
    if (out_result !== '0 || out_rd !== '0 || out_N !== 1'b0 || out_Z !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: got result=%h rd=%0d N=%b Z=%b want all zero", out_result, out_rd, out_N, out_Z);
    end
  endtask

  task automatic test_step();
    s_div = 1'b0; s_hi = 32'd5; s_lo = 32'd3; s_opnd = 32'd10;
    #1;
    vectors++;
    if (s_hi_next !== 32'd7 || s_lo_next !== 32'h8000_0001) begin
      errors++;
      $display("FAIL step_mul: got %h_%h want 00000007_80000001", s_hi_next, s_lo_next);
    end
    s_div = 1'b1; s_hi = 32'd3; s_lo = 32'h8000_0000; s_opnd = 32'd5;
    #1;
    vectors++;
    if (s_hi_next !== 32'd2 || s_lo_next !== 32'd1) begin
      errors++;
      $display("FAIL step_div_sub: got %h_%h want 00000002_00000001", s_hi_next, s_lo_next);
    end
    s_hi = 32'd1; s_lo = 32'h0000_0004;
    #1;
    vectors++;
    if (s_hi_next !== 32'd2 || s_lo_next !== 32'd8) begin
      errors++;
      $display("FAIL step_div_restore: got %h_%h want 00000002_00000008", s_hi_next, s_lo_next);
    end
  endtask

  task automatic test_arith();
    logic [2:0]      t_op  [14];
    logic [XLEN-1:0] t_a   [14];
    logic [XLEN-1:0] t_b   [14];
    logic [XLEN-1:0] t_exp [14];
    int              t_lat [14];
    int              lat;
    t_op  = '{F3_MUL, F3_MULH, F3_MULHU, F3_MULHSU, F3_DIV, F3_REM, F3_DIVU, F3_REMU,
              F3_DIV, F3_REM, F3_DIVU, F3_REMU, F3_DIV, F3_REM};
    t_a   = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
              32'd100, 32'd100, 32'd7, 32'd7, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    t_b   = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2,
              32'd7, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    t_exp = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
              32'd14, 32'd2, 32'hFFFF_FFFD, 32'd1, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    t_lat = '{34, 34, 34, 34, 34, 34, 34, 34, 34, 34, 2, 2, 2, 2};
    for (int i = 0; i < 14; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], REG_AW'(i + 1), lat);
      vectors++;
      if (lat !== t_lat[i]) begin
        errors++;
        $display("FAIL latency[%0d]: got %0d edges want %0d", i, lat, t_lat[i]);
      end
      vectors++;
      if (out_result !== t_exp[i] || out_rd !== REG_AW'(i + 1)) begin
        errors++;
        $display("FAIL result[%0d] op=%0d: got %h rd=%0d want %h rd=%0d", i, t_op[i], out_result, out_rd, t_exp[i], i + 1);
      end
      vectors++;
      if (out_N !== t_exp[i][XLEN-1] || out_Z !== (t_exp[i] == '0)) begin
        errors++;
        $display("FAIL flags[%0d]: got N=%b Z=%b want N=%b Z=%b", i, out_N, out_Z, t_exp[i][XLEN-1], (t_exp[i] == '0));
      end
      release_result();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    run_op(F3_DIVU, 32'd100, 32'd7, 5'd17, lat);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || out_result !== 32'd14 || out_rd !== 5'd17 || in_ready !== 1'b0 || stall !== 1'b1) begin
        errors++;
        $display("FAIL hold[%0d]: got valid=%b result=%h rd=%0d ready=%b stall=%b want 1 0000000e 17 0 1",
                 k, out_valid, out_result, out_rd, in_ready, stall);
      end
    end
    // A request offered in the DONE cycle must not be taken.
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_op = F3_MUL; in_a = 32'd3; in_b = 32'd3;
    @(posedge clk);
    #1;
    in_valid = 1'b0; out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || stall !== 1'b0) begin
      errors++;
      $display("FAIL release: got valid=%b ready=%b stall=%b want 0 1 0", out_valid, in_ready, stall);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL no_bypass: got stall=%b want 0", stall);
    end
  endtask

  task automatic test_kill();
    int lat;
    logic seen;
    @(negedge clk);
    in_op = F3_MULHU; in_a = '1; in_b = '1; in_rd = 5'd9; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    vectors++;
    if (in_ready !== 1'b1 || stall !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL kill_idle: got ready=%b stall=%b valid=%b want 1 0 0", in_ready, stall, out_valid);
    end
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL kill_discard: got out_valid rise=%b want 0", seen);
    end
    run_op(F3_DIVU, 32'd100, 32'd7, 5'd21, lat);
    vectors++;
    if (lat !== 34 || out_result !== 32'd14 || out_rd !== 5'd21) begin
      errors++;
      $display("FAIL after_kill: got lat=%0d result=%h rd=%0d want 34 0000000e 21", lat, out_result, out_rd);
    end
    release_result();
  endtask

  task automatic test_rst_mid();
    int lat;
    @(negedge clk);
    in_op = F3_MUL; in_a = 32'd6; in_b = 32'd7; in_rd = 5'd4; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || stall !== 1'b0 || out_result !== '0 ||
        out_rd !== '0 || out_N !== 1'b0 || out_Z !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: got ready=%b valid=%b stall=%b result=%h rd=%0d N=%b Z=%b want 1 0 0 0 0 0 0",
               in_ready, out_valid, stall, out_result, out_rd, out_N, out_Z);
    end
    run_op(F3_MUL, 32'd6, 32'd7, 5'd4, lat);
    vectors++;
    if (lat !== 34 || out_result !== 32'd42) begin
      errors++;
      $display("FAIL after_rst: got lat=%0d result=%h want 34 0000002a", lat, out_result);
    end
    release_result();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_step();
    test_arith();
    test_backpressure();
    test_kill();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
